id_scoreboard_ctrl: RTL and testbench
=====================================

// Module: id_scoreboard_ctrl
// PURPOSE
//  Issue controller for the decode stage. Tracks in-flight register writes with a
//  per-register pending counter, stalls decode when a source or the destination is
//  busy, squashes decode on a taken branch, and keeps stall statistics.
//  Sits beside the decode stage: consumes decoded source/dest fields, drives its hazard input.
// PARAMETERS
//  NREG      16   architectural registers (index width = $clog2(NREG))
//  CNT_W     2    pending-counter width; max in-flight writes per reg = 2**CNT_W-1
//  TIMEOUT   64   consecutive stall cycles before sticky deadlock flag
//  PERF_W    32   stall-cycle performance counter width
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, synchronous, active-low
//  id_valid   in   1       decode holds a valid instruction
//  id_src1    in   4       first source register index
//  id_src2    in   4       second source register index
//  id_two_src in   1       id_src2 is a real operand
//  id_wb_en   in   1       decoded instruction writes id_dest
//  id_dest    in   4       destination register index
//  br_taken   in   1       branch taken resolved downstream; squash decode
//  wb_en      in   1       writeback retiring a write this cycle
//  wb_dest    in   4       writeback destination index
//  hazard     out  1       stall fetch/decode (combinational)
//  issue      out  1       instruction leaves decode this cycle (combinational)
//  flush      out  1       registered squash pulse to the fetch/decode register
//  pend_mask  out  NREG    bit r = pending counter r nonzero
//  stall_cnt  out  PERF_W  saturating count of cycles with hazard=1
//  deadlock   out  1       sticky; stall run reached TIMEOUT
// BEHAVIOUR
//  Reset (rst=0 at clk edge): all pending counters 0, flush 0, stall_cnt 0,
//   deadlock 0, stall-run counter 0; hazard/issue 0 because pend_mask is 0 and
//   issue is forced 0 while rst=0.
//  RAW: raw = pend[id_src1] | (id_two_src & pend[id_src2]).
//  WAW limit: full = cnt[id_dest]==2**CNT_W-1 while id_wb_en.
//  hazard = id_valid & ~br_taken & (raw | full).
//  issue  = id_valid & ~br_taken & ~hazard & rst.
//  Counter update per register r, each cycle:
//   inc = issue & id_wb_en & id_dest==r; dec = wb_en & wb_dest==r.
//   inc&dec -> unchanged; inc only -> +1; dec only -> -1.
//   dec on counter 0 -> stays 0 (no underflow; a stray writeback is ignored).
//  Bypass: none. Writeback clearing a source's pend lifts the hazard the NEXT cycle,
//   since the register file write completes in the same edge.
//  flush: registered br_taken, 1-cycle latency; back-to-back br_taken gives
//   back-to-back pulses. br_taken overrides hazard (nothing issues, nothing stalls).
//  Stall FSM: IDLE -> STALL when hazard=1; STALL -> IDLE when hazard=0.
//   Run counter increments in STALL, clears on return to IDLE.
//   Run counter reaching TIMEOUT sets deadlock; deadlock is cleared only by reset.
//   stall_cnt +1 each hazard cycle, saturates at all-ones.
//  Reset asserted mid-stall or with writes in flight discards all pending state;
//   writebacks arriving after reset hit counter 0 and are ignored.
// STRUCTURE
//  Shared package: NREG, REG_IDX_W, the stall FSM state enum {IDLE, STALL},
//   and the pend-counter typedef logic [CNT_W-1:0].
//  Sub-module: pend_counter, one per register (generate loop): inc/dec/saturation
//   and nonzero flag. Top level holds the source/dest muxes, FSM, perf counter and deadlock logic.
// TESTING
//  1) Issue write r3, then reader of r3 -> hazard=1 until wb_en/wb_dest=3,
//     issue=1 the following cycle; stall_cnt equals the stall cycles.
//  2) Three issued writes to r5 (CNT_W=2) -> 4th write stalls (full);
//     one wb of r5 -> issue next cycle; pend_mask[5] clears after 3 more wbs.
//  3) Same cycle: issue writes r7 and wb_en retires r7 -> cnt[7] unchanged;
//     wb_dest=9 with cnt[9]=0 -> stays 0.
//  4) br_taken=1 while hazard condition present -> hazard=0, issue=0,
//     flush=1 next cycle only.
//  5) Source pending, no writeback for 64 cycles -> deadlock=1 and sticky;
//     then rst=0 one cycle -> all outputs 0, pend_mask=0.
//  6) id_two_src=0 with id_src2 pending -> no hazard; set to 1 -> hazard.

Source files
------------

// File: rtl/id_scoreboard_ctrl_pkg.sv
// Shared types for the decode-stage issue scoreboard: register indexing, pending
// counters, the stall FSM states and the decoded-instruction packet.
package id_scoreboard_ctrl_pkg;

  localparam int NREG      = 16;
  localparam int REG_IDX_W = $clog2(NREG);
  localparam int CNT_W     = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]     pend_cnt_t;

  localparam pend_cnt_t CNT_MAX  = '1;
  localparam pend_cnt_t CNT_ZERO = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_e;

  typedef struct packed {
    logic     vld;
    reg_idx_t src1;
    reg_idx_t src2;
    logic     two_src;
    logic     wb_en;
    reg_idx_t dest;
  } dec_t;

  function automatic logic [NREG-1:0] idx_dec(input reg_idx_t idx);
    logic [NREG-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/id_scoreboard_ctrl_pend_counter.sv
// Per-register in-flight write counter: holds at max on increment, never underflows
// on a stray decrement; simultaneous inc/dec leaves the count unchanged.
module id_scoreboard_ctrl_pend_counter
  import id_scoreboard_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic nz_o,
  output logic full_o
);

  pend_cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nz_o   = (cnt_q != CNT_ZERO);
  assign full_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// Decode issue controller: combinational hazard/issue from per-register pending
// counters, registered branch flush (1 cycle), stall statistics and sticky deadlock.
module id_scoreboard_ctrl
  import id_scoreboard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int PERF_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  reg_idx_t          id_src1_i,
  input  reg_idx_t          id_src2_i,
  input  logic              id_two_src_i,
  input  logic              id_wb_en_i,
  input  reg_idx_t          id_dest_i,
  input  logic              br_taken_i,
  input  logic              wb_en_i,
  input  reg_idx_t          wb_dest_i,
  output logic              hazard_o,
  output logic              issue_o,
  output logic              flush_o,
  output logic [NREG-1:0]   pend_mask_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic              deadlock_o
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_TO = RUN_W'(TIMEOUT);

  dec_t            dec;
  logic [NREG-1:0] full_vec;
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;
  logic            raw;
  logic            waw_full;

  assign dec = '{vld:     id_valid_i,
                 src1:    id_src1_i,
                 src2:    id_src2_i,
                 two_src: id_two_src_i,
                 wb_en:   id_wb_en_i,
                 dest:    id_dest_i};

  // No bypass: a source stays blocked until its counter has actually dropped.
  assign raw      = pend_mask_o[dec.src1] | (dec.two_src & pend_mask_o[dec.src2]);
  assign waw_full = dec.wb_en & full_vec[dec.dest];
  assign hazard_o = dec.vld & ~br_taken_i & (raw | waw_full);
  assign issue_o  = dec.vld & ~br_taken_i & ~hazard_o & rst_i;

  assign inc_vec = {NREG{issue_o & dec.wb_en}} & idx_dec(dec.dest);
  assign dec_vec = {NREG{wb_en_i}} & idx_dec(wb_dest_i);

  for (genvar r = 0; r < NREG; r++) begin : g_pend
    id_scoreboard_ctrl_pend_counter u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (inc_vec[r]),
      .dec_i  (dec_vec[r]),
      .nz_o   (pend_mask_o[r]),
      .full_o (full_vec[r])
    );
  end

  // Stall FSM
  stall_state_e state_q, state_d;
  logic         run_start, run_inc, run_clr;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hazard_o)  state_d = STALL;
      STALL:   if (!hazard_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_start = 1'b0;
    run_inc   = 1'b0;
    run_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        run_start = hazard_o;
        run_clr   = ~hazard_o;
      end
      STALL: begin
        run_inc = hazard_o;
        run_clr = ~hazard_o;
      end
      default: run_clr = 1'b1;
    endcase
  end

  // Run counter holds the length of the current hazard run, so deadlock rises on
  // the edge that closes the TIMEOUT-th consecutive stall cycle.
  logic [RUN_W-1:0]  run_q, run_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              deadlock_q, deadlock_d;
  logic              flush_q;

  always_comb begin
    run_d = run_q;
    if (run_clr) begin
      run_d = '0;
    end else if (run_start) begin
      run_d = RUN_W'(1);
    end else if (run_inc && (run_q != RUN_TO)) begin
      run_d = run_q + 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  assign deadlock_d = deadlock_q | (run_d == RUN_TO);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      run_q       <= '0;
      stall_cnt_q <= '0;
      deadlock_q  <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      run_q       <= run_d;
      stall_cnt_q <= stall_cnt_d;
      deadlock_q  <= deadlock_d;
      flush_q     <= br_taken_i;
    end
  end

  assign flush_o     = flush_q;
  assign stall_cnt_o = stall_cnt_q;
  assign deadlock_o  = deadlock_q;

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Directed bench for id_scoreboard_ctrl with a per-cycle reference model and
// hand-computed literal checkpoints.
module tb_id_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_two_src, id_wb_en, br_taken, wb_en;
  logic [3:0]  id_src1, id_src2, id_dest, wb_dest;
  logic        hazard, issue, flush, deadlock;
  logic [15:0] pend_mask;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: plain counts, not the RTL's structure.
  int     m_cnt[16];
  bit     m_flush;
  longint m_stall;
  int     m_run;
  bit     m_dead;

  always #5 clk = ~clk;

  id_scoreboard_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (id_valid),
    .id_src1_i    (id_src1),
    .id_src2_i    (id_src2),
    .id_two_src_i (id_two_src),
    .id_wb_en_i   (id_wb_en),
    .id_dest_i    (id_dest),
    .br_taken_i   (br_taken),
    .wb_en_i      (wb_en),
    .wb_dest_i    (wb_dest),
    .hazard_o     (hazard),
    .issue_o      (issue),
    .flush_o      (flush),
    .pend_mask_o  (pend_mask),
    .stall_cnt_o  (stall_cnt),
    .deadlock_o   (deadlock)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard();
    bit busy;
    busy = (m_cnt[id_src1] > 0) || (id_two_src && m_cnt[id_src2] > 0) ||
           (id_wb_en && m_cnt[id_dest] == 3);
    return id_valid && !br_taken && busy;
  endfunction

  function automatic bit m_issue(input bit hz);
    return id_valid && !br_taken && !hz && rst;
  endfunction

  function automatic logic [15:0] m_mask();
    logic [15:0] m;
    for (int r = 0; r < 16; r++) m[r] = (m_cnt[r] != 0);
    return m;
  endfunction

  always @(posedge clk) begin
    bit hz, is;
    if (!rst) begin
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      m_flush = 0; m_stall = 0; m_run = 0; m_dead = 0;
    end else begin
      hz = m_hazard();
      is = m_issue(hz);
      if (is && id_wb_en) m_cnt[id_dest] = m_cnt[id_dest] + 1;
      if (wb_en && m_cnt[wb_dest] > 0) m_cnt[wb_dest] = m_cnt[wb_dest] - 1;
      m_flush = br_taken;
      if (hz && m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
      m_run = hz ? m_run + 1 : 0;
      if (m_run >= 64) m_dead = 1;
    end
  end

  always @(negedge clk) begin
    bit hz;
    if (chk_en) begin
      hz = m_hazard();
      chk("hazard", {31'b0, hazard}, {31'b0, hz});
      chk("issue", {31'b0, issue}, {31'b0, m_issue(hz)});
      chk("flush", {31'b0, flush}, {31'b0, m_flush});
      chk("pend_mask", {16'b0, pend_mask}, {16'b0, m_mask()});
      chk("stall_cnt", stall_cnt, m_stall[31:0]);
      chk("deadlock", {31'b0, deadlock}, {31'b0, m_dead});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                     input logic two, input logic we, input logic [3:0] d);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two; id_wb_en = we; id_dest = d;
  endtask

  task automatic wb(input logic en, input logic [3:0] d);
    wb_en = en; wb_dest = d;
  endtask

  initial begin
    rst = 1'b0; br_taken = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    wb(0, 0);
    tick(); tick();
    rst = 1'b1;
    chk_en = 1'b1;
    #2;
    chk("rst_pend", {16'b0, pend_mask}, 32'h0);
    chk("rst_stall", stall_cnt, 32'h0);
    chk("rst_dead", {31'b0, deadlock}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);

    // 1) RAW on r3 until writeback
    drv(1, 0, 0, 0, 1, 3);
    #2 chk("t1_issue_wr", {31'b0, issue}, 32'h1);
    tick();
    drv(1, 3, 0, 0, 0, 0);
    #2 chk("t1_hazard", {31'b0, hazard}, 32'h1);
    chk("t1_mask", {16'b0, pend_mask}, 32'h0008);
    tick(); tick();
    wb(1, 3);
    #2 chk("t1_hazard_wb", {31'b0, hazard}, 32'h1);
    tick();
    wb(0, 0);
    #2 chk("t1_issue_next", {31'b0, issue}, 32'h1);
    chk("t1_stall_cnt", stall_cnt, 32'd3);
    tick();

    // 2) WAW limit on r5
    drv(1, 0, 0, 0, 1, 5);
    tick(); tick(); tick();
    #2 chk("t2_full", {31'b0, hazard}, 32'h1);
    chk("t2_mask", {16'b0, pend_mask}, 32'h0020);
    tick();
    wb(1, 5);
    #2 chk("t2_full_wb", {31'b0, hazard}, 32'h1);
    tick();
    wb(0, 0);
    #2 chk("t2_issue", {31'b0, issue}, 32'h1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    wb(1, 5);
    tick(); tick();
    #2 chk("t2_mask_2wb", {16'b0, pend_mask}, 32'h0020);
    tick();
    wb(0, 0);
    #2 chk("t2_mask_3wb", {16'b0, pend_mask}, 32'h0000);
    chk("t2_stall_cnt", stall_cnt, 32'd5);

    // 3) simultaneous inc/dec on r7, stray writeback to r9
    drv(1, 0, 0, 0, 1, 7);
    tick();
    wb(1, 7);
    #2 chk("t3_issue", {31'b0, issue}, 32'h1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    wb(0, 0);
    #2 chk("t3_mask_same", {16'b0, pend_mask}, 32'h0080);
    wb(1, 7);
    tick();
    wb(1, 9);
    #2 chk("t3_mask_clr", {16'b0, pend_mask}, 32'h0000);
    tick();
    wb(0, 0);
    #2 chk("t3_no_underflow", {16'b0, pend_mask}, 32'h0000);

    // 4) branch squash overrides hazard
    drv(1, 0, 0, 0, 1, 2);
    tick();
    drv(1, 2, 0, 0, 0, 0);
    br_taken = 1'b1;
    #2 chk("t4_hazard", {31'b0, hazard}, 32'h0);
    chk("t4_issue", {31'b0, issue}, 32'h0);
    tick();
    br_taken = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    #2 chk("t4_flush", {31'b0, flush}, 32'h1);
    tick();
    #2 chk("t4_flush_off", {31'b0, flush}, 32'h0);
    br_taken = 1'b1;
    tick(); tick();
    br_taken = 1'b0;
    #2 chk("t4_flush_b2b", {31'b0, flush}, 32'h1);
    tick();

    // 6) second source qualified by id_two_src (r2 still pending)
    drv(1, 0, 2, 0, 0, 0);
    #2 chk("t6_no_hazard", {31'b0, hazard}, 32'h0);
    tick();
    drv(1, 0, 2, 1, 0, 0);
    #2 chk("t6_hazard", {31'b0, hazard}, 32'h1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick();

    // 5) deadlock after 64 consecutive stall cycles, then reset
    drv(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 63; i++) tick();
    chk("t5_dead_63", {31'b0, deadlock}, 32'h0);
    tick();
    chk("t5_dead_64", {31'b0, deadlock}, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    drv(0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_sticky", {31'b0, deadlock}, 32'h1);
    drv(1, 0, 0, 0, 1, 4);
    rst = 1'b0;
    #2 chk("t5_issue_rst", {31'b0, issue}, 32'h0);
    tick();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    #2 chk("t5_mask", {16'b0, pend_mask}, 32'h0);
    chk("t5_dead", {31'b0, deadlock}, 32'h0);
    chk("t5_stall", stall_cnt, 32'h0);
    chk("t5_hazard", {31'b0, hazard}, 32'h0);
    wb(1, 2);
    tick();
    wb(0, 0);
    #2 chk("t5_stray_wb", {16'b0, pend_mask}, 32'h0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
